// File: rtl/booth_seq_mult.sv
// Sequential radix-4 Booth multiplier, 8x8 unsigned -> 16-bit product.
// Optional early termination on zero upper multiplier bits: BOOTH_SEQ_SKIPZERO_EN.
module booth_seq_mult (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] product,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [7:0]  a_q;
  logic [7:0]  b_q;
  logic [17:0] acc;
  logic [2:0]  idx;

  logic [10:0] b_ext;
  logic [2:0]  trip;
  logic [2:0]  act;
  logic [17:0] mag;
  logic [17:0] shf;
  logic [17:0] term;
  logic        last;

  // Booth recode of the current group and its signed, shifted term
  always_comb begin
    b_ext = {2'b00, b_q, 1'b0};
    trip  = 3'(b_ext >> {idx, 1'b0});
    act   = 3'b000;
    unique case (trip)
      3'b001,
      3'b010:  act = 3'b001;
      3'b011:  act = 3'b010;
      3'b100:  act = 3'b110;
      3'b101,
      3'b110:  act = 3'b101;
      default: act = 3'b000;
    endcase
    mag = '0;
    if (act[1])
      mag = {9'd0, a_q, 1'b0};
    else if (act[0])
      mag = {10'd0, a_q};
    shf  = mag << {idx, 1'b0};
    term = act[2] ? -shf : shf;
`ifdef BOOTH_SEQ_SKIPZERO_EN
    last = (idx == 3'd4) ||
           ((b_q >> {idx, 1'b1}) == 8'd0);
`else
    last = (idx == 3'd4);
`endif
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nx;
  end

  // Next state and state-decoded handshake outputs
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid)
          state_nx = CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (last)
          state_nx = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Operand latch and accumulate datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
      acc <= '0;
      idx <= '0;
    end else if (state == IDLE && in_valid) begin
      a_q <= a;
      b_q <= b;
      acc <= '0;
      idx <= '0;
    end else if (state == CALC) begin
      acc <= acc + term;
      idx <= idx + 3'd1;
    end
  end

  assign product = acc[15:0];

endmodule

// File: tb/tb_booth_seq_mult.sv
// Randomized self-checking bench for booth_seq_mult.
// Reference: plain a*b and group count from the multiplier's upper bits.
module tb_booth_seq_mult;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] product;
  logic        busy;

  int vectors;
  int miscompares;

  booth_seq_mult dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected CALC cycles for a multiplier value
  function automatic int exp_groups(input logic [7:0] bv);
    int k;
`ifdef BOOTH_SEQ_SKIPZERO_EN
    k = 0;
    while (k < 4 && (int'(bv) >> (2 * k + 1)) != 0)
      k++;
    return k + 1;
`else
    return 5;
`endif
  endfunction

  // Drives one operation; returns observations for the caller to check
  task automatic run_op(
    input  logic [7:0]  av,
    input  logic [7:0]  bv,
    input  int          hold,
    output int          lat,
    output logic [15:0] prod,
    output int          calc_bad,
    output int          hold_bad,
    output logic        post_ok
  );
    a         = av;
    b         = bv;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a        = 8'($urandom);
    b        = 8'($urandom);
    lat      = 0;
    calc_bad = 0;
    hold_bad = 0;
    while (!out_valid && lat < 20) begin
      if (in_ready || !busy)
        calc_bad++;
      in_valid = 1'($urandom);
      @(posedge clk);
      #1;
      lat++;
    end
    prod = product;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom);
      a        = 8'($urandom);
      b        = 8'($urandom);
      @(posedge clk);
      #1;
      if (!out_valid || product !== prod || in_ready)
        hold_bad++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    post_ok   = !out_valid && in_ready && !busy;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    #2;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 ||
        busy !== 1'b0 || product !== 16'h0) begin
      miscompares++;
      $display("FAIL reset: got rdy=%b vld=%b busy=%b p=%h want 1 0 0 0000",
               in_ready, out_valid, busy, product);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_directed();
    logic [7:0]  av [6];
    logic [7:0]  bv [6];
    logic [15:0] pv [6];
    int          lat;
    logic [15:0] prod;
    int          cb;
    int          hb;
    logic        ok;
    av = '{8'hFF, 8'h12, 8'h80, 8'hAB, 8'h00, 8'h37};
    bv = '{8'hFF, 8'h34, 8'h80, 8'h00, 8'hCD, 8'h01};
    pv = '{16'hFE01, 16'h03A8, 16'h4000,
           16'h0000, 16'h0000, 16'h0037};
    for (int i = 0; i < 6; i++) begin
      run_op(av[i], bv[i], 0, lat, prod, cb, hb, ok);
      vectors++;
      if (prod !== pv[i]) begin
        miscompares++;
        $display("FAIL dir_prod[%0d]: got %h want %h", i, prod, pv[i]);
      end
      vectors++;
      if (lat != exp_groups(bv[i])) begin
        miscompares++;
        $display("FAIL dir_lat[%0d]: got %0d want %0d",
                 i, lat, exp_groups(bv[i]));
      end
      vectors++;
      if (cb != 0 || !ok) begin
        miscompares++;
        $display("FAIL dir_hs[%0d]: got calc_bad=%0d post_ok=%b want 0 1",
                 i, cb, ok);
      end
    end
  endtask

  task automatic test_backpressure();
    int          lat;
    logic [15:0] prod;
    int          cb;
    int          hb;
    logic        ok;
    run_op(8'hC3, 8'h5A, 10, lat, prod, cb, hb, ok);
    vectors++;
    if (prod !== 16'(8'hC3 * 8'h5A)) begin
      miscompares++;
      $display("FAIL bp_prod: got %h want %h", prod, 16'(8'hC3 * 8'h5A));
    end
    vectors++;
    if (hb != 0) begin
      miscompares++;
      $display("FAIL bp_hold: got %0d unstable cycles want 0", hb);
    end
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL bp_release: got post_ok=0 want 1");
    end
  endtask

  task automatic test_rst_mid();
    int          lat;
    logic [15:0] prod;
    int          cb;
    int          hb;
    logic        ok;
    a        = 8'hEE;
    b        = 8'hDD;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 ||
        busy !== 1'b0 || product !== 16'h0) begin
      miscompares++;
      $display("FAIL rst_mid: got rdy=%b vld=%b busy=%b p=%h want 1 0 0 0000",
               in_ready, out_valid, busy, product);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_idle: got vld=%b rdy=%b want 0 1", out_valid, in_ready);
    end
    run_op(8'h05, 8'h07, 0, lat, prod, cb, hb, ok);
    vectors++;
    if (prod !== 16'h0023 || lat != exp_groups(8'h07)) begin
      miscompares++;
      $display("FAIL rst_next: got p=%h lat=%0d want 0023 %0d",
               prod, lat, exp_groups(8'h07));
    end
  endtask

  task automatic test_random();
    logic [7:0]  av;
    logic [7:0]  bv;
    int          lat;
    logic [15:0] prod;
    int          cb;
    int          hb;
    logic        ok;
    int          hold;
    for (int n = 0; n < 1000; n++) begin
      av   = 8'($urandom);
      bv   = 8'($urandom);
      if (n % 8 == 0)
        bv = 8'($urandom_range(0, 7));
      hold = int'($urandom_range(0, 3));
      run_op(av, bv, hold, lat, prod, cb, hb, ok);
      vectors++;
      if (prod !== 16'(av * bv) || lat != exp_groups(bv) ||
          cb != 0 || hb != 0 || !ok) begin
        miscompares++;
        $display("FAIL rand[%0d] a=%h b=%h: got p=%h lat=%0d cb=%0d hb=%0d ok=%b want p=%h lat=%0d 0 0 1",
                 n, av, bv, prod, lat, cb, hb, ok,
                 16'(av * bv), exp_groups(bv));
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_directed();
    test_backpressure();
    test_rst_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
